move_swap_engine: RTL
=====================

Name: move_swap_engine

Overview:
- Sequential executor for packed move/swap commands against a single-port u32 register-file memory.
- Takes a decoded command (two operands, each either a direct address or a pointer through memory, plus a single-flag condition), resolves the operands and swaps the two words.
- Sits between the instruction decode stage and the shared execution-environment memory.
- It is the consuming end of the move argument encoding.

Parameters:
- ADDR_W, 8, memory address width; pointer values are truncated to their low ADDR_W bits.
- DATA_W, 32, memory word width.
- NFLAGS, 8, number of condition flags on flags_in.
- SEL_W, 3, width of the flag select; the select must be able to index NFLAGS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine can accept a command
- cmd_addr1  in  ADDR_W  operand 1: address, or pointer location
- cmd_addr2  in  ADDR_W  operand 2: address, or pointer location
- cmd_ptr1  in  1  1 = operand 1 is indirect (location = mem[cmd_addr1])
- cmd_ptr2  in  1  1 = operand 2 is indirect
- cmd_cond_en  in  1  0 = always execute
- cmd_cond_sel  in  SEL_W  flag index
- cmd_cond_pol  in  1  required flag value
- flags_in  in  NFLAGS  condition flags
- mem_req  out  1  memory access this cycle
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read request
- done_valid  out  1  command finished
- done_ready  in  1  consumer accepts completion
- done_skipped  out  1  condition was false; no memory access occurred

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 the cycle after; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done_valid=0, done_skipped=0; state=IDLE.
- Accept: a command is accepted when cmd_valid & cmd_ready at edge T.
  - cmd_ready=1 only in IDLE.
  - All command fields and flags_in are captured at T; later changes are ignored.
- Condition: cond_true = !cmd_cond_en || (flags_in[cmd_cond_sel] == cmd_cond_pol).
  - A select >= NFLAGS evaluates false.
  - False -> go to RESP with skipped=1; no mem_req is issued; done_valid=1 at T+1.
- States: IDLE, P1_RD, P1_CAP, P2_RD, P2_CAP, D1_RD, D1_CAP, D2_RD, D2_CAP, WR1, WR2, RESP.
- Transitions:
  - IDLE -> P1_RD if ptr1, else P2_RD if ptr2, else D1_RD.
  - P1_RD -> P1_CAP -> (P2_RD if ptr2, else D1_RD).
  - P2_RD -> P2_CAP -> D1_RD.
  - D1_RD -> D1_CAP -> D2_RD -> D2_CAP -> WR1 -> WR2 -> RESP.
- *_RD states: mem_req=1, mem_we=0, mem_addr = respective address. *_CAP states capture mem_rdata with mem_req=0.
- Location rules:
  - loc1 = ptr1 ? mem[addr1][ADDR_W-1:0] : addr1; loc2 is formed the same way from operand 2.
  - Both pointer reads complete before any data read.
  - Both data reads complete before any write, so all values are pre-swap.
- Writes:
  - WR1: mem[loc1] = old mem[loc2].
  - WR2: mem[loc2] = old mem[loc1].
  - mem_req=1, mem_we=1.
  - If loc1 == loc2, WR1 and WR2 are still issued; both write the same old value, so the word is unchanged.
- Latency: done_valid rises at T+7 with both operands direct; each indirect operand adds 2 cycles (max T+11).
- RESP: done_valid=1 and done_skipped are held until done_ready; leave to IDLE on done_valid & done_ready. cmd_ready=1 the next cycle. Back-to-back command throughput is therefore latency + 1.
- mem outputs are 0 whenever mem_req=0.
- Reset mid-operation: state goes to IDLE at the next edge and the in-flight command is dropped with no completion. If reset lands between WR1 and WR2, the partial swap (only WR1 done) is accepted behaviour.
- cmd_valid while busy: held off; cmd_ready=0 and nothing is captured.

Test Plan:
- Direct swap: mem[3]=0xAAAA0001, mem[7]=0xBBBB0002; cmd addr1=3, addr2=7, ptr=0, cond_en=0.
  - Response: done_valid at T+7, skipped=0.
  - mem[3]=0xBBBB0002, mem[7]=0xAAAA0001.
  - Exactly 4 mem_req cycles.
- Double indirect: mem[1]=0x10, mem[2]=0x20, mem[0x10]=5, mem[0x20]=9; cmd addr1=1 ptr1=1, addr2=2 ptr2=1.
  - Response: done at T+11; mem[0x10]=9, mem[0x20]=5; mem[1] and mem[2] unchanged.
  - Pointer value 0x110 with ADDR_W=8 resolves to 0x10.
- Condition false: cond_en=1, sel=2, pol=1, flags_in=0.
  - Response: done_valid at T+1, done_skipped=1, mem_req never asserted.
  - With flags_in=0x04 the swap executes normally.
- Same location: addr1=4, addr2=4, mem[4]=0x1234.
  - Response: two writes of 0x1234; mem[4]=0x1234 afterwards; done at T+7.
- Done backpressure and busy: hold done_ready=0 for 5 cycles.
  - done_valid and done_skipped stay stable; cmd_ready stays 0; a cmd_valid pulse during busy is not captured.
  - After done_ready, the next command is accepted the following cycle.
- Reset mid-op: assert reset during D2_CAP.
  - Response: next cycle mem_req=0, done_valid=0, all outputs at reset values; cmd_ready=1 the cycle after reset deasserts; memory unchanged.

Source files
------------

// File: rtl/move_swap_engine.sv
// move_swap_engine: resolves two direct/indirect operands through a single-port memory and swaps the addressed words
module move_swap_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NFLAGS = 8,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr1,
  input  logic [ADDR_W-1:0] cmd_addr2,
  input  logic              cmd_ptr1,
  input  logic              cmd_ptr2,
  input  logic              cmd_cond_en,
  input  logic [SEL_W-1:0]  cmd_cond_sel,
  input  logic              cmd_cond_pol,
  input  logic [NFLAGS-1:0] flags_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              done_skipped
);
  localparam logic [3:0] IDLE = 4'd0, P1_RD = 4'd1, P1_CAP = 4'd2, P2_RD = 4'd3, P2_CAP = 4'd4,
                         D1_RD = 4'd5, D1_CAP = 4'd6, D2_RD = 4'd7, D2_CAP = 4'd8,
                         WR1 = 4'd9, WR2 = 4'd10, RESP = 4'd11;
  logic [3:0] state;
  logic [ADDR_W-1:0] a1, a2;
  logic [DATA_W-1:0] d1, d2;
  logic p2, skipped, cond_true;
  always_comb cond_true = !cmd_cond_en ||
                          (int'(cmd_cond_sel) < NFLAGS && flags_in[cmd_cond_sel] == cmd_cond_pol);
  // a1/a2 hold the operand addresses until a pointer capture replaces them with the resolved location
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          a1 <= cmd_addr1;
          a2 <= cmd_addr2;
          p2 <= cmd_ptr2;
          skipped <= !cond_true;
          state <= !cond_true ? RESP : cmd_ptr1 ? P1_RD : cmd_ptr2 ? P2_RD : D1_RD;
        end
        P1_CAP: begin
          a1 <= mem_rdata[ADDR_W-1:0];
          state <= p2 ? P2_RD : D1_RD;
        end
        P2_CAP: begin
          a2 <= mem_rdata[ADDR_W-1:0];
          state <= D1_RD;
        end
        D1_CAP: begin
          d1 <= mem_rdata;
          state <= D2_RD;
        end
        D2_CAP: begin
          d2 <= mem_rdata;
          state <= WR1;
        end
        RESP: if (done_ready) state <= IDLE;
        default: state <= state + 4'd1;
      endcase
    end
  always_comb begin
    cmd_ready = state == IDLE && !reset;
    mem_req = state inside {P1_RD, P2_RD, D1_RD, D2_RD, WR1, WR2};
    mem_we = state inside {WR1, WR2};
    mem_addr = state inside {P1_RD, D1_RD, WR1} ? a1 : state inside {P2_RD, D2_RD, WR2} ? a2 : '0;
    mem_wdata = state == WR1 ? d2 : state == WR2 ? d1 : '0;
    done_valid = state == RESP;
    done_skipped = done_valid && skipped;
  end
endmodule
